// File: rtl/apb_exe_ctrl.sv
// APB slave front-end for a pipelined execution unit: holds operands and
// operation code, launches an operation on a CTRL start write, and captures
// the unit's result and status as they emerge from its pipeline.
module apb_exe_ctrl #(
    parameter int N = 2,
    parameter int M = 8
) (
    input  logic          i_clk,
    input  logic          i_rsn,
    input  logic          i_psel,
    input  logic          i_penable,
    input  logic          i_pwrite,
    input  logic [7:0]    i_paddr,
    input  logic [31:0]   i_pwdata,
    output logic [31:0]   o_prdata,
    output logic          o_pready,
    output logic          o_pslverr,
    output logic [N-1:0]  o_oper,
    output logic [M-1:0]  o_argA,
    output logic [M-1:0]  o_argB,
    input  logic [M-1:0]  i_result,
    input  logic [3:0]    i_status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RES,
        S_STAT
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [N-1:0]   ctrl_oper;
    logic [M-1:0]   arg_a;
    logic [M-1:0]   arg_b;
    logic [M-1:0]   result_q;
    logic [3:0]     status_q;
    logic           done_q;

    logic           busy;
    logic           access;
    logic           sel_ctrl;
    logic           sel_arga;
    logic           sel_argb;
    logic           sel_result;
    logic           sel_stat;
    logic           mapped;
    logic           stall;
    logic           complete;
    logic           wr_bad;
    logic           rd_bad;
    logic           wr_ok;
    logic           start;
    logic [31:0]    rdata;
    logic           pwdata_unused;

    // Only the low bits of write data matter for any register.
    assign pwdata_unused = ^i_pwdata;

    // Address decode, stall and error qualification for the current APB cycle.
    always_comb begin
        busy       = (state_q != S_IDLE);
        access     = i_psel & i_penable;
        sel_ctrl   = (i_paddr == 8'h00);
        sel_arga   = (i_paddr == 8'h04);
        sel_argb   = (i_paddr == 8'h08);
        sel_result = (i_paddr == 8'h0C);
        sel_stat   = (i_paddr == 8'h10);
        mapped     = sel_ctrl | sel_arga | sel_argb | sel_result | sel_stat;
        // Result/status reads wait until the capture has happened.
        stall      = access & ~i_pwrite & (sel_result | sel_stat) & busy;
        complete   = access & ~stall;
        wr_bad     = i_pwrite & (~mapped | sel_result | sel_stat |
                                 (sel_ctrl & i_pwdata[0] & busy));
        rd_bad     = ~i_pwrite & ~mapped;
        wr_ok      = complete & i_pwrite & ~wr_bad;
        start      = wr_ok & sel_ctrl & i_pwdata[0];
    end

    // Read data mux; zero outside a completing, non-erroneous read.
    always_comb begin
        rdata = '0;
        if (complete && !i_pwrite && !i_rsn) begin
            if (sel_ctrl) begin
                rdata[N:0] = {ctrl_oper, 1'b0};
            end else if (sel_arga) begin
                rdata[M-1:0] = arg_a;
            end else if (sel_argb) begin
                rdata[M-1:0] = arg_b;
            end else if (sel_result) begin
                rdata[M-1:0] = result_q;
            end else if (sel_stat) begin
                rdata[5:0] = {busy, done_q, status_q};
            end
        end
    end

    // APB response outputs, forced to idle values while reset is held.
    always_comb begin
        o_prdata  = rdata;
        o_pready  = i_rsn | ~stall;
        o_pslverr = ~i_rsn & complete & (wr_bad | rd_bad);
    end

    // Sequencer: one cycle each for load, result capture and status capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_RES;
            S_RES:   state_d = S_STAT;
            S_STAT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register file, operand launch and pipeline captures.
    always_ff @(posedge i_clk or posedge i_rsn) begin
        if (i_rsn) begin
            ctrl_oper <= '0;
            arg_a     <= '0;
            arg_b     <= '0;
            result_q  <= '0;
            status_q  <= '0;
            done_q    <= 1'b0;
            o_oper    <= '0;
            o_argA    <= '0;
            o_argB    <= '0;
        end else begin
            if (wr_ok && sel_ctrl) ctrl_oper <= i_pwdata[N:1];
            if (wr_ok && sel_arga) arg_a <= i_pwdata[M-1:0];
            if (wr_ok && sel_argb) arg_b <= i_pwdata[M-1:0];
            // The launched oper comes straight from the write data so a
            // start can carry its own operation code.
            if (start) begin
                o_oper <= i_pwdata[N:1];
                o_argA <= arg_a;
                o_argB <= arg_b;
                done_q <= 1'b0;
            end
            if (state_q == S_RES) result_q <= i_result;
            if (state_q == S_STAT) begin
                status_q <= i_status;
                done_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_exe_ctrl.sv
// Directed bench for apb_exe_ctrl with a stub execution unit
// (result = argA ^ argB after 1 cycle, status = {oper, 2'b01} after 2).
module tb_apb_exe_ctrl;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  oper;
    logic [7:0]  arg_a;
    logic [7:0]  arg_b;
    logic [7:0]  result;
    logic [3:0]  status;
    logic [1:0]  oper_d;

    int checks   = 0;
    int failures = 0;

    apb_exe_ctrl #(.N(2), .M(8)) dut (
        .i_clk     (clk),
        .i_rsn     (rst),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .o_prdata  (prdata),
        .o_pready  (pready),
        .o_pslverr (pslverr),
        .o_oper    (oper),
        .o_argA    (arg_a),
        .o_argB    (arg_b),
        .i_result  (result),
        .i_status  (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execution unit stub.
    always_ff @(posedge clk) begin
        result <= arg_a ^ arg_b;
        oper_d <= oper;
        status <= {oper_d, 2'b01};
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        int unsigned n;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        n = 0;
        while (!pready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!pready) chk("wr_ready_timeout", {31'b0, pready}, 32'h1);
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    endtask

    // setup=0 enters the access phase directly (back-to-back with the
    // preceding transfer).
    task automatic apb_read(input logic [7:0] a, input logic setup, output logic [31:0] d,
                            output logic err, output int stalls);
        int unsigned n;
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        if (setup) begin
            @(posedge clk); #1;
        end
        penable = 1'b1;
        #1;
        n = 0;
        while (!pready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!pready) chk("rd_ready_timeout", {31'b0, pready}, 32'h1);
        stalls = int'(n);
        d   = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic        err;
        logic [31:0] d;
        int          st;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oper",    {30'b0, oper}, 32'h0);
        chk("rst_argA",    {24'b0, arg_a}, 32'h0);
        chk("rst_argB",    {24'b0, arg_b}, 32'h0);
        chk("rst_pready",  {31'b0, pready}, 32'h1);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_prdata",  prdata, 32'h0);
        rst = 1'b0;

        // First start right after reset: oper=1, args 0.
        apb_write(8'h00, 32'h03, err);
        chk("first_start_err", {31'b0, err}, 32'h0);
        chk("first_start_oper", {30'b0, oper}, 32'h1);
        apb_read(8'h10, 1'b1, d, err, st);
        chk("first_stat", d, 32'h15);

        // Basic operation: 0x3C ^ 0x0F, oper=2.
        apb_write(8'h04, 32'h3C, err);
        apb_write(8'h08, 32'h0F, err);
        apb_write(8'h00, 32'h05, err);
        chk("op1_start_err", {31'b0, err}, 32'h0);
        chk("op1_oper", {30'b0, oper}, 32'h2);
        chk("op1_argA", {24'b0, arg_a}, 32'h3C);
        chk("op1_argB", {24'b0, arg_b}, 32'h0F);
        apb_read(8'h0C, 1'b0, d, err, st);
        chk("op1_stalls", st, 3);
        chk("op1_result", d, 32'h33);
        chk("op1_result_err", {31'b0, err}, 32'h0);
        apb_read(8'h10, 1'b1, d, err, st);
        chk("op1_stat", d, 32'h19);

        // Second start while busy is rejected.
        apb_write(8'h04, 32'h12, err);
        apb_write(8'h08, 32'h34, err);
        apb_write(8'h00, 32'h03, err);
        apb_write(8'h00, 32'h05, err);
        chk("busy_start_err", {31'b0, err}, 32'h1);
        apb_read(8'h0C, 1'b1, d, err, st);
        chk("busy_start_result", d, 32'h26);
        apb_read(8'h10, 1'b1, d, err, st);
        chk("busy_start_stat", d, 32'h15);
        apb_read(8'h00, 1'b1, d, err, st);
        chk("busy_start_ctrl", d, 32'h02);
        chk("busy_start_oper", {30'b0, oper}, 32'h1);

        // Operand write during busy only affects the next operation.
        apb_write(8'h04, 32'h3C, err);
        apb_write(8'h08, 32'h0F, err);
        apb_write(8'h00, 32'h05, err);
        apb_write(8'h04, 32'hFF, err);
        chk("busy_arga_err", {31'b0, err}, 32'h0);
        chk("busy_arga_out", {24'b0, arg_a}, 32'h3C);
        apb_read(8'h0C, 1'b1, d, err, st);
        chk("busy_arga_result", d, 32'h33);
        apb_read(8'h04, 1'b1, d, err, st);
        chk("arga_readback", d, 32'hFF);
        apb_write(8'h00, 32'h05, err);
        apb_read(8'h0C, 1'b0, d, err, st);
        chk("next_op_result", d, 32'hF0);

        // CTRL write without start: oper field only, upper bits ignored.
        apb_write(8'h00, 32'hFE, err);
        chk("ctrl_nostart_err", {31'b0, err}, 32'h0);
        apb_read(8'h00, 1'b1, d, err, st);
        chk("ctrl_nostart_read", d, 32'h06);
        chk("ctrl_nostart_oper", {30'b0, oper}, 32'h2);

        // Error responses.
        apb_read(8'h14, 1'b1, d, err, st);
        chk("unmapped_rd_err", {31'b0, err}, 32'h1);
        chk("unmapped_rd_data", d, 32'h0);
        apb_write(8'h0C, 32'h55, err);
        chk("wr_result_err", {31'b0, err}, 32'h1);
        apb_write(8'h10, 32'h55, err);
        chk("wr_stat_err", {31'b0, err}, 32'h1);
        apb_read(8'h02, 1'b1, d, err, st);
        chk("unaligned_rd_err", {31'b0, err}, 32'h1);
        apb_read(8'h0C, 1'b1, d, err, st);
        chk("after_err_result", d, 32'hF0);
        chk("after_err_result_err", {31'b0, err}, 32'h0);

        // Reset during the RES state aborts the operation.
        apb_write(8'h04, 32'hAA, err);
        apb_write(8'h00, 32'h05, err);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_oper", {30'b0, oper}, 32'h0);
        chk("midrst_argA", {24'b0, arg_a}, 32'h0);
        chk("midrst_argB", {24'b0, arg_b}, 32'h0);
        chk("midrst_prdata", prdata, 32'h0);
        chk("midrst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("midrst_pready", {31'b0, pready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apb_read(8'h10, 1'b1, d, err, st);
        chk("postrst_stat", d, 32'h00);
        apb_read(8'h04, 1'b1, d, err, st);
        chk("postrst_arga", d, 32'h00);
        apb_write(8'h04, 32'h5A, err);
        apb_write(8'h08, 32'hA5, err);
        apb_write(8'h00, 32'h03, err);
        apb_read(8'h0C, 1'b0, d, err, st);
        chk("postrst_result", d, 32'hFF);
        apb_read(8'h10, 1'b1, d, err, st);
        chk("postrst_stat_done", d, 32'h15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_exe_ctrl.md
APB_EXE_CTRL -- requirements
Module: apb_exe_ctrl

Interface
REQ-001 SHALL have parameter N, default 2, operation-code width.
REQ-002 SHALL have parameter M, default 8, operand/result width (M <= 32).
REQ-003 SHALL have port i_clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port i_rsn, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have APB slave inputs i_psel (1), i_penable (1), i_pwrite (1), i_paddr (8), i_pwdata (32).
REQ-006 SHALL have APB slave outputs o_prdata (32), o_pready (1), o_pslverr (1).
REQ-007 SHALL drive the execution unit with o_oper (N), o_argA (M), o_argB (M), all registered.
REQ-008 SHALL accept i_result (M) and i_status (4) from the execution unit, whose result register updates 1 cycle after its inputs and whose status register updates 1 cycle after its result.

Function
REQ-009 Access cycle = i_psel & i_penable; transfer completes when o_pready=1 in an access cycle; setup cycles have no side effects.
REQ-010 Register map (word addresses): 0x00 CTRL (W: [0] start, [N:1] oper; R: [N:1] oper, [0] reads 0); 0x04 ARGA [M-1:0] RW; 0x08 ARGB [M-1:0] RW; 0x0C RESULT [M-1:0] RO; 0x10 STAT RO ([3:0] captured status, [4] done, [5] busy).
REQ-011 Unused write bits ignored; unused read bits return 0.
REQ-012 o_pready=1 in every access cycle, except a RESULT or STAT read while busy=1: o_pready held 0 until the cycle after busy falls, then 1 with fresh data.
REQ-013 o_pslverr=1 only in the completing access cycle, for: unmapped address, write to RESULT/STAT, write to CTRL with start=1 while busy=1; erroneous writes change no state; unmapped reads return 0.
REQ-014 o_prdata valid only in completing access cycle, 0 otherwise.
REQ-015 Start accepted in cycle T (CTRL write, start=1, busy=0): on edge ending T, o_oper/o_argA/o_argB load from CTRL.oper/ARGA/ARGB (including same-cycle oper from i_pwdata), busy->1, done->0.
REQ-016 FSM IDLE -> LOAD (T+1) -> RES (T+2) -> STAT (T+3) -> IDLE; one state per cycle, no stalls.
REQ-017 RESULT register captures i_result on edge ending RES; STAT[3:0] captures i_status on edge ending STAT; on that same edge busy->0, done->1.
REQ-018 busy=1 exactly during LOAD, RES, STAT (3 cycles); done stays 1 until next accepted start or reset.
REQ-019 o_oper/o_argA/o_argB remain constant from load until next accepted start; ARGA/ARGB/oper writes while busy are legal and affect only the next operation.
REQ-020 CTRL write with start=0 updates oper field only, no operation.

Reset
REQ-021 While i_rsn=1: FSM=IDLE; CTRL, ARGA, ARGB, RESULT, STAT, o_oper, o_argA, o_argB = 0; o_prdata=0, o_pslverr=0, o_pready=1.
REQ-022 Reset mid-operation aborts it; no capture occurs; done=0 after release; a stalled APB read is abandoned (master also reset).
REQ-023 First start is accepted in the first access cycle after i_rsn falls.

Verification (execution unit replaced by 1-cycle result / 2-cycle status pipeline stub: result=argA^argB, status=oper concatenated with 2'b01)
REQ-024 Write ARGA=0x3C, ARGB=0x0F, CTRL=0x05 (oper=2, start) -> busy=1 for 3 cycles; RESULT=0x33, STAT=0x19 (done=1, busy=0, status=4'h9).
REQ-025 Start then immediate RESULT read -> o_pready=0 for 3 access cycles, then 1 with o_prdata=0x33, o_pslverr=0.
REQ-026 Second start during busy -> o_pslverr=1, FSM unaffected, RESULT equals first operation's result.
REQ-027 Write ARGA=0xFF during busy -> current result unchanged; next start uses 0xFF.
REQ-028 Read 0x14, write 0x0C -> o_pslverr=1, o_prdata=0, registers unchanged.
REQ-029 Assert i_rsn in RES state -> all outputs 0, STAT reads 0x00 after release, next start completes normally.
